// File: rtl/sysid_pkg.sv
// Shared types and constants for the sysid probe master and its helpers.
package sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_WT_ID = 3'd2,
        ST_RD_TS = 3'd3,
        ST_WT_TS = 3'd4,
        ST_FIN   = 3'd5
    } sysid_state_e;

    localparam logic [31:0] SYSID_ID_OFS = 32'd0;
    localparam logic [31:0] SYSID_TS_OFS = 32'd4;

    // Bits needed to hold max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only master/slave signal bundle used by the sysid probe.
interface sysid_probe_master_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sysid_timeout_cnt.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module sysid_timeout_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM read master that reads the sysid ID and timestamp words and checks them.
// Define SYSID_RECHECK_EN to add a periodic automatic recheck timer.
module sysid_probe_master
    import sysid_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = 32'd911120,
    parameter logic [31:0] EXPECTED_TS    = 32'd1402342180,
    parameter int unsigned TIMEOUT_CYCLES = 256
`ifdef SYSID_RECHECK_EN
    , parameter int unsigned RECHECK_PERIOD = 1048576
`endif
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    sysid_probe_master_if.master        avm,
    output logic                        busy,
    output logic                        done,
    output logic                        id_ok,
    output logic                        ts_ok,
    output logic                        timeout,
    output logic [31:0]                 id_value,
    output logic [31:0]                 ts_value
);

    localparam int unsigned     TMO_W    = cnt_width(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    sysid_state_e state_q, state_d;
    logic         avm_read_q, avm_read_d;
    logic [31:0]  avm_address_q, avm_address_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         id_ok_q, id_ok_d;
    logic         ts_ok_q, ts_ok_d;
    logic         timeout_q, timeout_d;
    logic [31:0]  id_value_q, id_value_d;
    logic [31:0]  ts_value_q, ts_value_d;
    logic         boot_q, boot_d;

    logic         accept;
    logic         capture;
    logic         start_eff;
    logic         recheck_fire;
    logic         tmo_load;
    logic         tmo_en;
    logic         tmo_expired;

    assign accept = avm_read_q && !avm.avm_waitrequest;
    // Data is only taken in the wait state or alongside the accepting cycle; stray beats are dropped.
    assign capture = avm.avm_readdatavalid &&
                     (accept || (state_q == ST_WT_ID) || (state_q == ST_WT_TS));
    assign start_eff = start || boot_q || recheck_fire;
    assign tmo_en    = (state_q != ST_IDLE) && (state_q != ST_FIN);

    sysid_timeout_cnt #(
        .WIDTH (TMO_W)
    ) u_timeout_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .en       (tmo_en),
        .expired  (tmo_expired)
    );

`ifdef SYSID_RECHECK_EN
    localparam int unsigned     RCK_W    = cnt_width(RECHECK_PERIOD - 1);
    localparam logic [RCK_W-1:0] RCK_LOAD = RCK_W'(RECHECK_PERIOD - 1);

    logic rck_expired;

    sysid_timeout_cnt #(
        .WIDTH (RCK_W)
    ) u_recheck_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     ((state_q == ST_FIN) || rck_expired),
        .load_val (RCK_LOAD),
        .en       (1'b1),
        .expired  (rck_expired)
    );

    assign recheck_fire = rck_expired;
`else
    assign recheck_fire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_d     = timeout_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        boot_d        = 1'b0;
        tmo_load      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_eff) begin
                    state_d       = ST_RD_ID;
                    avm_read_d    = 1'b1;
                    avm_address_d = BASE_ADDR + SYSID_ID_OFS;
                    busy_d        = 1'b1;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_d     = 1'b0;
                    tmo_load      = 1'b1;
                end
            end
            ST_RD_ID, ST_WT_ID: begin
                if (capture) begin
                    id_value_d    = avm.avm_readdata;
                    id_ok_d       = (avm.avm_readdata == EXPECTED_ID);
                    state_d       = ST_RD_TS;
                    avm_read_d    = 1'b1;
                    avm_address_d = BASE_ADDR + SYSID_TS_OFS;
                    tmo_load      = 1'b1;
                end else if (tmo_expired) begin
                    state_d    = ST_FIN;
                    avm_read_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                end else if (accept) begin
                    state_d    = ST_WT_ID;
                    avm_read_d = 1'b0;
                end
            end
            ST_RD_TS, ST_WT_TS: begin
                if (capture) begin
                    ts_value_d = avm.avm_readdata;
                    ts_ok_d    = (avm.avm_readdata == EXPECTED_TS);
                    state_d    = ST_FIN;
                    avm_read_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (tmo_expired) begin
                    state_d    = ST_FIN;
                    avm_read_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                end else if (accept) begin
                    state_d    = ST_WT_TS;
                    avm_read_d = 1'b0;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // boot_q resets high so the first clock after reset release acts as a start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            avm_read_q    <= 1'b0;
            avm_address_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
            boot_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
            boot_q        <= boot_d;
        end
    end

    assign avm.avm_read    = avm_read_q;
    assign avm.avm_address = avm_address_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout         = timeout_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;

endmodule
